// File: rtl/tl_sink_allocator.sv
// tl_sink_allocator: sink-ID pool with round-robin allocation and GrantAck release
module tl_sink_allocator #(
  parameter int SinkWidth = 2,
  parameter int NumReq    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumReq-1:0]         req_valid_i,
  output logic [NumReq-1:0]         req_ready_o,
  output logic [SinkWidth-1:0]      gnt_sink_o,
  input  logic                      e_valid_i,
  output logic                      e_ready_o,
  input  logic [SinkWidth-1:0]      e_sink_i,
  output logic [(2**SinkWidth)-1:0] busy_o,
  output logic [SinkWidth:0]        free_count_o,
  output logic                      idle_o,
  output logic                      err_o
);
  localparam int NumSinks = 2**SinkWidth;
  localparam int PtrW = NumReq > 1 ? $clog2(NumReq) : 1;

  logic [NumSinks-1:0] busy_q, busy_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d, winner;
  logic [SinkWidth:0]  count_q, count_d;
  logic                err_q, err_d, any_free, found, alloc, rel_ok;

  // Selection and arbitration look only at registered state and req_valid_i.
  always_comb begin
    gnt_sink_o = '0;
    any_free = 1'b0;
    for (int i = NumSinks - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        gnt_sink_o = SinkWidth'(i);
        any_free = 1'b1;
      end
    end
    winner = '0;
    found = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      if (!found && req_valid_i[(int'(rr_ptr_q) + k) % NumReq]) begin
        found = 1'b1;
        winner = PtrW'((int'(rr_ptr_q) + k) % NumReq);
      end
    end
    req_ready_o = (found && any_free && rst_ni) ? NumReq'(1) << winner : '0;
  end

  assign alloc  = |req_ready_o;
  assign rel_ok = e_valid_i && busy_q[e_sink_i];

  // The allocated ID is free in busy_q, so it can never collide with a valid release.
  always_comb begin
    busy_d = busy_q;
    if (alloc) busy_d[gnt_sink_o] = 1'b1;
    if (rel_ok) busy_d[e_sink_i] = 1'b0;
    count_d = count_q + (SinkWidth+1)'(alloc) - (SinkWidth+1)'(rel_ok);
    rr_ptr_d = !alloc ? rr_ptr_q : (winner == PtrW'(NumReq - 1)) ? '0 : winner + 1'b1;
    err_d = err_q || (e_valid_i && !busy_q[e_sink_i]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign e_ready_o    = 1'b1;
  assign busy_o       = busy_q;
  assign free_count_o = (SinkWidth+1)'(NumSinks) - count_q;
  assign idle_o       = (count_q == '0);
  assign err_o        = err_q;
endmodule

// File: tb/tb_tl_sink_allocator.sv
// tb_tl_sink_allocator: directed stimulus with a grant scoreboard for tl_sink_allocator
module tb_tl_sink_allocator;
  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [1:0] req = '0;
  logic [1:0] req_ready;
  logic [1:0] gnt_sink;
  logic       e_valid = 1'b0;
  logic       e_ready;
  logic [1:0] e_sink = '0;
  logic [3:0] busy;
  logic [2:0] free_count;
  logic       idle, err;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];

  tl_sink_allocator #(.SinkWidth(2), .NumReq(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req), .req_ready_o(req_ready),
    .gnt_sink_o(gnt_sink), .e_valid_i(e_valid), .e_ready_o(e_ready), .e_sink_i(e_sink),
    .busy_o(busy), .free_count_o(free_count), .idle_o(idle), .err_o(err)
  );

  always #5 clk = ~clk;

  // Monitor: every grant (and every cycle a grant is expected) pops one expectation.
  always @(negedge clk) begin
    if (|req_ready || exp_q.size() > 0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_grant: got ready=%b sink=%0d, required no grant", req_ready, gnt_sink);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if ({req_ready, gnt_sink} !== e) begin
          miscompares++;
          $display("FAIL grant: got ready=%b sink=%0d, required ready=%b sink=%0d",
                   req_ready, gnt_sink, e[3:2], e[1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] r, input logic ev, input logic [1:0] es);
    @(posedge clk);
    #1;
    req = r;
    e_valid = ev;
    e_sink = es;
  endtask

  task automatic expg(input logic [1:0] rdy, input logic [1:0] sink);
    exp_q.push_back({rdy, sink});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    req = '0;
    e_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic chk_status(input string tag, input logic [3:0] b, input logic [2:0] f, input logic i, input logic e);
    chk({tag, "_busy"}, 8'(busy), 8'(b));
    chk({tag, "_free"}, 8'(free_count), 8'(f));
    chk({tag, "_idle"}, 8'(idle), 8'(i));
    chk({tag, "_err"}, 8'(err), 8'(e));
  endtask

  initial begin
    req = 2'b11;
    #3;
    chk("reset_ready", 8'(req_ready), 8'h0);
    chk("e_ready", 8'(e_ready), 8'h1);
    chk_status("reset", 4'b0000, 3'd4, 1'b1, 1'b0);
    req = '0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // single request
    step(2'b01, 1'b0, 2'd0); expg(2'b01, 2'd0);
    step(2'b00, 1'b0, 2'd0);
    chk_status("single", 4'b0001, 3'd3, 1'b0, 1'b0);

    // round-robin fairness
    do_reset();
    step(2'b11, 1'b0, 2'd0); expg(2'b01, 2'd0);
    step(2'b11, 1'b0, 2'd0); expg(2'b10, 2'd1);
    step(2'b11, 1'b0, 2'd0); expg(2'b01, 2'd2);
    step(2'b11, 1'b0, 2'd0); expg(2'b10, 2'd3);
    step(2'b11, 1'b0, 2'd0);
    chk("rr_full_ready", 8'(req_ready), 8'h0);
    chk("rr_full_free", 8'(free_count), 8'h0);

    // full-pool recovery: release in cycle N, regrant in N+1
    step(2'b11, 1'b1, 2'd2);
    chk("full_ready_N", 8'(req_ready), 8'h0);
    step(2'b11, 1'b0, 2'd0); expg(2'b01, 2'd2);
    step(2'b00, 1'b0, 2'd0);
    chk_status("recover", 4'b1111, 3'd0, 1'b0, 1'b0);

    // simultaneous allocation and release
    do_reset();
    step(2'b11, 1'b0, 2'd0); expg(2'b01, 2'd0);
    step(2'b11, 1'b0, 2'd0); expg(2'b10, 2'd1);
    step(2'b01, 1'b1, 2'd0); expg(2'b01, 2'd2);
    chk("simul_free_before", 8'(free_count), 8'd2);
    step(2'b00, 1'b0, 2'd0);
    chk_status("simul", 4'b0110, 3'd2, 1'b0, 1'b0);

    // spurious GrantAck
    do_reset();
    step(2'b00, 1'b1, 2'd3);
    step(2'b00, 1'b0, 2'd0);
    chk_status("spurious", 4'b0000, 3'd4, 1'b1, 1'b1);
    step(2'b00, 1'b0, 2'd0);
    step(2'b00, 1'b0, 2'd0);
    chk("spurious_sticky", 8'(err), 8'h1);
    do_reset();
    chk("spurious_cleared", 8'(err), 8'h0);

    // reset mid-operation with busy = 1011
    step(2'b11, 1'b0, 2'd0); expg(2'b01, 2'd0);
    step(2'b11, 1'b0, 2'd0); expg(2'b10, 2'd1);
    step(2'b11, 1'b0, 2'd0); expg(2'b01, 2'd2);
    step(2'b11, 1'b0, 2'd0); expg(2'b10, 2'd3);
    step(2'b00, 1'b1, 2'd2);
    step(2'b00, 1'b0, 2'd0);
    chk("mid_busy_before", 8'(busy), 8'b1011);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_status("mid_reset", 4'b0000, 3'd4, 1'b1, 1'b0);
    step(2'b00, 1'b0, 2'd0);
    rst_ni = 1'b1;
    step(2'b11, 1'b1, 2'd0); expg(2'b01, 2'd0);
    step(2'b00, 1'b0, 2'd0);
    chk_status("post_reset", 4'b0001, 3'd3, 1'b0, 1'b1);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
